instruction_fetcher: RTL and testbench



---
 rtl/instruction_fetcher.sv | 141 ++++++++++++++
 tb/tb_instruction_fetcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - single-outstanding fetch stage feeding predictor and instruction queue
// Optional macro FETCH_BRANCH_PRED_EN: BRANCH taken decision follows pred_jump (else static not-taken).
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              ic_req_valid,
  input  logic              ic_req_ready,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_rsp_valid,
  input  logic [INST_W-1:0] ic_rsp_inst,
  output logic [ADDR_W-1:0] pred_addr,
  input  logic              pred_jump,
  input  logic              iq_full,
  output logic              iq_valid,
  output logic [INST_W-1:0] iq_inst,
  output logic [ADDR_W-1:0] iq_pc,
  output logic              iq_pred_jump,
  input  logic              rob_flush,
  input  logic [ADDR_W-1:0] rob_redirect_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_next_pc;
  logic [INST_W-1:0] r_iq_inst;
  logic [ADDR_W-1:0] r_iq_pc;
  logic              r_iq_pred;

  logic              w_accept;
  logic              w_live;
  logic              w_push;
  logic              w_br_taken;
  logic              w_taken;
  logic [6:0]        w_opcode;
  logic [ADDR_W-1:0] w_imm_j;
  logic [ADDR_W-1:0] w_imm_b;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_opcode = ic_rsp_inst[6:0];
  assign w_imm_j  = ADDR_W'($signed({ic_rsp_inst[31], ic_rsp_inst[19:12], ic_rsp_inst[20],
                                     ic_rsp_inst[30:21], 1'b0}));
  assign w_imm_b  = ADDR_W'($signed({ic_rsp_inst[31], ic_rsp_inst[7], ic_rsp_inst[30:25],
                                     ic_rsp_inst[11:8], 1'b0}));

`ifdef FETCH_BRANCH_PRED_EN
  assign w_br_taken = pred_jump;
`else
  // pred_jump is deliberately ignored in the static not-taken build
  assign w_br_taken = 1'b0 & pred_jump;
`endif

  always_comb begin
    w_taken   = 1'b0;
    w_next_pc = r_pc + ADDR_W'(4);
    if (w_opcode == OP_JAL) begin
      w_taken   = 1'b1;
      w_next_pc = r_pc + w_imm_j;
    end else if (w_opcode == OP_BRANCH && w_br_taken) begin
      w_taken   = 1'b1;
      w_next_pc = r_pc + w_imm_b;
    end
  end

  assign ic_req_valid = rst_in && (r_state == S_IDLE);
  assign ic_req_addr  = r_pc;
  assign pred_addr    = r_pc;
  assign w_accept     = rdy_in && ic_req_valid && ic_req_ready;

  // Response is forwarded combinationally in its arrival cycle; HOLD replays the latched copy
  assign w_live   = rdy_in && !rob_flush && (r_state == S_WAIT) && ic_rsp_valid;
  assign w_push   = rdy_in && !rob_flush && !iq_full &&
                    (((r_state == S_WAIT) && ic_rsp_valid) || (r_state == S_HOLD));
  assign iq_valid     = w_push;
  assign iq_inst      = w_live ? ic_rsp_inst : r_iq_inst;
  assign iq_pc        = w_live ? r_pc        : r_iq_pc;
  assign iq_pred_jump = w_live ? w_taken     : r_iq_pred;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_pc      <= ADDR_W'(RESET_PC);
      r_next_pc <= '0;
      r_iq_inst <= '0;
      r_iq_pc   <= '0;
      r_iq_pred <= 1'b0;
    end else if (rdy_in) begin
      if (rob_flush) begin
        r_pc <= rob_redirect_pc;
        case (r_state)
          S_IDLE:  r_state <= w_accept ? S_DROP : S_IDLE;
          S_WAIT:  r_state <= ic_rsp_valid ? S_IDLE : S_DROP;
          S_HOLD:  r_state <= S_IDLE;
          default: r_state <= S_DROP;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (ic_rsp_valid) begin
              r_iq_inst <= ic_rsp_inst;
              r_iq_pc   <= r_pc;
              r_iq_pred <= w_taken;
              r_next_pc <= w_next_pc;
              if (!iq_full) begin
                r_pc    <= w_next_pc;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!iq_full) begin
              r_pc    <= r_next_pc;
              r_state <= S_IDLE;
            end
          end
          default: begin
            if (ic_rsp_valid) r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - directed vector bench for instruction_fetcher
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_inst;
  logic [31:0] pred_addr;
  logic        pred_jump;
  logic        iq_full;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_jump;
  logic        rob_flush;
  logic [31:0] rob_redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

`ifdef FETCH_BRANCH_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pj;
    logic        exp_pj;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[7];

  instruction_fetcher dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_inst(ic_rsp_inst),
    .pred_addr(pred_addr), .pred_jump(pred_jump),
    .iq_full(iq_full), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_pred_jump(iq_pred_jump),
    .rob_flush(rob_flush), .rob_redirect_pc(rob_redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] pc);
    @(negedge clk);
    ic_req_ready = 1'b0; rob_flush = 1'b1; rob_redirect_pc = pc;
    @(negedge clk);
    rob_flush = 1'b0;
  endtask

  task automatic accept();
    ic_req_ready = 1'b1;
    @(negedge clk);
    ic_req_ready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    set_pc(vecs[i].pc);
    #1;
    chk($sformatf("v%0d req_addr", i), ic_req_addr, vecs[i].pc);
    chk($sformatf("v%0d pred_addr", i), pred_addr, vecs[i].pc);
    chk($sformatf("v%0d req_valid", i), 32'(ic_req_valid), 32'd1);
    accept();
    chk($sformatf("v%0d wait req_valid", i), 32'(ic_req_valid), 32'd0);
    ic_rsp_valid = 1'b1; ic_rsp_inst = vecs[i].inst; pred_jump = vecs[i].pj;
    #1;
    chk($sformatf("v%0d iq_valid", i), 32'(iq_valid), 32'd1);
    chk($sformatf("v%0d iq_pc", i), iq_pc, vecs[i].pc);
    chk($sformatf("v%0d iq_inst", i), iq_inst, vecs[i].inst);
    chk($sformatf("v%0d iq_pred_jump", i), 32'(iq_pred_jump), 32'(vecs[i].exp_pj));
    @(negedge clk);
    ic_rsp_valid = 1'b0; pred_jump = 1'b0;
    #1;
    chk($sformatf("v%0d next addr", i), ic_req_addr, vecs[i].exp_next);
    chk($sformatf("v%0d next req_valid", i), 32'(ic_req_valid), 32'd1);
    chk($sformatf("v%0d iq_valid low", i), 32'(iq_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 32'hFF9F_F06F, 1'b0, 1'b1, 32'h0000_00F8};
    vecs[1] = '{32'h0000_0200, 32'h0000_0863, 1'b1, PRED, PRED ? 32'h0000_0210 : 32'h0000_0204};
    vecs[2] = '{32'h0000_0200, 32'h0000_0863, 1'b0, 1'b0, 32'h0000_0204};
    vecs[3] = '{32'h0000_0300, 32'h0000_8067, 1'b1, 1'b0, 32'h0000_0304};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0080_006F, 1'b0, 1'b1, 32'h0000_0004};
    vecs[5] = '{32'h0000_0340, 32'hFE00_0EE3, 1'b1, PRED, PRED ? 32'h0000_033C : 32'h0000_0344};
    vecs[6] = '{32'h0000_1000, 32'h0000_0013, 1'b1, 1'b0, 32'h0000_1004};

    rst_in = 1'b0; rdy_in = 1'b1; ic_req_ready = 1'b0; ic_rsp_valid = 1'b0;
    ic_rsp_inst = '0; pred_jump = 1'b0; iq_full = 1'b0; rob_flush = 1'b0; rob_redirect_pc = '0;
    @(negedge clk); #1;
    chk("rst req_valid", 32'(ic_req_valid), 32'd0);
    chk("rst req_addr", ic_req_addr, 32'h0);
    chk("rst pred_addr", pred_addr, 32'h0);
    chk("rst iq_valid", 32'(iq_valid), 32'd0);
    chk("rst iq_inst", iq_inst, 32'h0);
    chk("rst iq_pc", iq_pc, 32'h0);
    chk("rst iq_pred", 32'(iq_pred_jump), 32'd0);
    @(negedge clk);
    rst_in = 1'b1;
    #1;
    chk("rel req_valid", 32'(ic_req_valid), 32'd1);

    // addi from reset PC, response one cycle after acceptance
    @(negedge clk);
    accept();
    ic_rsp_valid = 1'b1; ic_rsp_inst = 32'h0000_0013;
    #1;
    chk("addi iq_valid", 32'(iq_valid), 32'd1);
    chk("addi iq_pc", iq_pc, 32'h0);
    chk("addi iq_inst", iq_inst, 32'h13);
    @(negedge clk);
    ic_rsp_valid = 1'b0;
    #1;
    chk("addi next addr", ic_req_addr, 32'h4);

    for (int i = 0; i < 7; i++) run_vec(i);

    // queue full for 3 cycles at response time
    set_pc(32'h500);
    accept();
    ic_rsp_valid = 1'b1; ic_rsp_inst = 32'h0000_0013; iq_full = 1'b1;
    #1;
    chk("hold first iq_valid", 32'(iq_valid), 32'd0);
    @(negedge clk);
    ic_rsp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("hold iq_valid", 32'(iq_valid), 32'd0);
      chk("hold req_valid", 32'(ic_req_valid), 32'd0);
      chk("hold iq_pc", iq_pc, 32'h500);
      chk("hold iq_inst", iq_inst, 32'h13);
      @(negedge clk);
    end
    iq_full = 1'b0;
    #1;
    chk("hold release iq_valid", 32'(iq_valid), 32'd1);
    chk("hold release iq_pc", iq_pc, 32'h500);
    @(negedge clk); #1;
    chk("hold after iq_valid", 32'(iq_valid), 32'd0);
    chk("hold next addr", ic_req_addr, 32'h504);
    chk("hold next req_valid", 32'(ic_req_valid), 32'd1);

    // flush in WAIT, stale response two cycles later
    set_pc(32'h600);
    accept();
    rob_flush = 1'b1; rob_redirect_pc = 32'h400;
    #1;
    chk("flushw iq_valid", 32'(iq_valid), 32'd0);
    @(negedge clk);
    rob_flush = 1'b0;
    #1;
    chk("drop req_valid", 32'(ic_req_valid), 32'd0);
    @(negedge clk);
    ic_rsp_valid = 1'b1; ic_rsp_inst = 32'h0000_0013;
    #1;
    chk("drop iq_valid", 32'(iq_valid), 32'd0);
    @(negedge clk);
    ic_rsp_valid = 1'b0;
    #1;
    chk("drop next addr", ic_req_addr, 32'h400);
    chk("drop next req_valid", 32'(ic_req_valid), 32'd1);

    // flush in WAIT with response in the same cycle
    set_pc(32'h640);
    accept();
    rob_flush = 1'b1; rob_redirect_pc = 32'h480; ic_rsp_valid = 1'b1;
    #1;
    chk("flushrsp iq_valid", 32'(iq_valid), 32'd0);
    @(negedge clk);
    rob_flush = 1'b0; ic_rsp_valid = 1'b0;
    #1;
    chk("flushrsp req_valid", 32'(ic_req_valid), 32'd1);
    chk("flushrsp addr", ic_req_addr, 32'h480);

    // flush in IDLE in the same cycle the request is accepted
    ic_req_ready = 1'b1; rob_flush = 1'b1; rob_redirect_pc = 32'h900;
    @(negedge clk);
    ic_req_ready = 1'b0; rob_flush = 1'b0;
    #1;
    chk("idleflush req_valid", 32'(ic_req_valid), 32'd0);
    @(negedge clk);
    ic_rsp_valid = 1'b1;
    #1;
    chk("idleflush iq_valid", 32'(iq_valid), 32'd0);
    @(negedge clk);
    ic_rsp_valid = 1'b0;
    #1;
    chk("idleflush addr", ic_req_addr, 32'h900);
    chk("idleflush req_valid2", 32'(ic_req_valid), 32'd1);

    // stall for 4 cycles with the response pending
    set_pc(32'h700);
    accept();
    rdy_in = 1'b0; ic_rsp_valid = 1'b1; ic_rsp_inst = 32'h0000_0013;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall iq_valid", 32'(iq_valid), 32'd0);
      chk("stall req_valid", 32'(ic_req_valid), 32'd0);
      chk("stall pc", ic_req_addr, 32'h700);
      @(negedge clk);
    end
    rdy_in = 1'b1;
    #1;
    chk("stall release iq_valid", 32'(iq_valid), 32'd1);
    chk("stall release iq_pc", iq_pc, 32'h700);
    @(negedge clk);
    ic_rsp_valid = 1'b0;
    #1;
    chk("stall once iq_valid", 32'(iq_valid), 32'd0);
    chk("stall next addr", ic_req_addr, 32'h704);

    // reset in the middle of a fetch, late response ignored
    set_pc(32'h800);
    accept();
    rst_in = 1'b0;
    #1;
    chk("midrst req_valid", 32'(ic_req_valid), 32'd0);
    chk("midrst addr", ic_req_addr, 32'h0);
    chk("midrst iq_pc", iq_pc, 32'h0);
    @(negedge clk);
    rst_in = 1'b1; ic_rsp_valid = 1'b1; ic_rsp_inst = 32'h0000_006F;
    #1;
    chk("midrst rsp iq_valid", 32'(iq_valid), 32'd0);
    chk("midrst rsp req_valid", 32'(ic_req_valid), 32'd1);
    @(negedge clk);
    ic_rsp_valid = 1'b0;
    #1;
    chk("midrst addr hold", ic_req_addr, 32'h0);
    chk("midrst idle iq_valid", 32'(iq_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
